// File: rtl/align_pkg.sv
// Shared types and helpers for the exponent-alignment buffer: FSM state,
// output-width derivation and the saturated shift computation.
package align_pkg;

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } align_state_e;

    localparam int N_DEF       = 4;
    localparam int EXP_W_DEF   = 8;
    localparam int MANT_W_DEF  = 14;
    localparam int GUARD_W_DEF = 4;

    function automatic int out_width(input int mant_w, input int guard_w);
        return mant_w + guard_w;
    endfunction

    localparam int OUT_W = out_width(MANT_W_DEF, GUARD_W_DEF);

    // Clamp an exponent difference into [0, limit]; limit means "shifted out entirely".
    function automatic int sat_shift(input int diff, input int limit);
        if (diff < 0) begin
            return 0;
        end else if (diff > limit) begin
            return limit;
        end else begin
            return diff;
        end
    endfunction

endpackage

// File: rtl/align_shifter.sv
// Combinational right shifter for one mantissa with appended guard bits.
// Produces sticky (OR of dropped bits) when EXP_ALIGN_STICKY_EN is defined.
module align_shifter
    import align_pkg::*;
#(
    parameter int IN_W    = 14,
    parameter int GUARD_W = 4,
    parameter int SH_W    = 5
) (
    input  logic [IN_W-1:0]         mant_i,
    input  logic [SH_W-1:0]         shift_i,
    output logic [IN_W+GUARD_W-1:0] mant_o
`ifdef EXP_ALIGN_STICKY_EN
    ,
    output logic                    sticky_o
`endif
);

    localparam int SH_OUT_W = out_width(IN_W, GUARD_W);

    logic [SH_OUT_W-1:0] ext_s;

    assign ext_s = {mant_i, {GUARD_W{1'b0}}};

    // Aligned value; a shift of the full width or more empties the window.
    always_comb begin
        mant_o = '0;
        if (32'(shift_i) >= 32'(SH_OUT_W)) begin
            mant_o = '0;
        end else begin
            mant_o = ext_s >> shift_i;
        end
    end

`ifdef EXP_ALIGN_STICKY_EN
    logic [SH_OUT_W-1:0] drop_mask_s;

    // Mask of bit positions pushed below the LSB; all ones once shift reaches the width.
    always_comb begin
        drop_mask_s = ~({SH_OUT_W{1'b1}} << shift_i);
        sticky_o    = |(ext_s & drop_mask_s);
    end
`endif

endmodule

// File: rtl/exp_align_buffer.sv
// Buffers a group of N exponent/mantissa pairs, tracks the group maximum
// exponent, then drains each mantissa aligned to that maximum.
// Optional feature macro: EXP_ALIGN_STICKY_EN (adds out_sticky_o).
module exp_align_buffer
    import align_pkg::*;
#(
    parameter int N       = 4,
    parameter int EXP_W   = 8,
    parameter int MANT_W  = 14,
    parameter int GUARD_W = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [EXP_W:0]            in_exp_i,
    input  logic [MANT_W-1:0]         in_mant_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [MANT_W+GUARD_W-1:0] out_mant_o,
    output logic                      out_last_o,
    output logic [EXP_W:0]            max_exp_o
`ifdef EXP_ALIGN_STICKY_EN
    ,
    output logic                      out_sticky_o
`endif
);

    localparam int ALN_W = out_width(MANT_W, GUARD_W);
    localparam int SH_W  = $clog2(ALN_W + 1);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    align_state_e             state_q;
    logic [IDX_W-1:0]         idx_q;
    logic signed [EXP_W:0]    max_q;
    logic [EXP_W:0]           exp_buf_q  [N];
    logic [MANT_W-1:0]        mant_buf_q [N];

    logic                     drain_s;
    logic [EXP_W:0]           cur_exp_s;
    logic signed [EXP_W+1:0]  diff_s;
    logic [SH_W-1:0]          shift_s;
    logic [ALN_W-1:0]         aligned_s;

    // FSM, group buffer and running maximum; reset discards any partial or draining group.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FILL;
            idx_q   <= '0;
            max_q   <= '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (in_valid_i) begin
                        exp_buf_q[idx_q]  <= in_exp_i;
                        mant_buf_q[idx_q] <= in_mant_i;
                        if (idx_q == '0) begin
                            max_q <= $signed(in_exp_i);
                        end else if ($signed(in_exp_i) > max_q) begin
                            max_q <= $signed(in_exp_i);
                        end else begin
                            max_q <= max_q;
                        end
                        if (idx_q == IDX_LAST) begin
                            state_q <= DRAIN;
                            idx_q   <= '0;
                        end else begin
                            idx_q   <= idx_q + IDX_W'(1);
                        end
                    end else begin
                        idx_q <= idx_q;
                    end
                end
                DRAIN: begin
                    if (out_ready_i) begin
                        if (idx_q == IDX_LAST) begin
                            state_q <= FILL;
                            idx_q   <= '0;
                        end else begin
                            idx_q   <= idx_q + IDX_W'(1);
                        end
                    end else begin
                        idx_q <= idx_q;
                    end
                end
                default: begin
                    state_q <= FILL;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    assign drain_s   = (state_q == DRAIN);
    assign cur_exp_s = exp_buf_q[idx_q];
    // One extra bit keeps max - exp exact across the full signed exponent range.
    assign diff_s    = $signed({max_q[EXP_W], max_q}) - $signed({cur_exp_s[EXP_W], cur_exp_s});
    assign shift_s   = SH_W'(sat_shift(int'(diff_s), ALN_W));

`ifdef EXP_ALIGN_STICKY_EN
    logic sticky_s;
`endif

    align_shifter #(
        .IN_W    (MANT_W),
        .GUARD_W (GUARD_W),
        .SH_W    (SH_W)
    ) u_shifter (
        .mant_i   (mant_buf_q[idx_q]),
        .shift_i  (shift_s),
        .mant_o   (aligned_s)
`ifdef EXP_ALIGN_STICKY_EN
        ,
        .sticky_o (sticky_s)
`endif
    );

    // Output decode from registered state only; data outputs are zero outside DRAIN.
    always_comb begin
        in_ready_o  = ~drain_s;
        out_valid_o = drain_s;
        max_exp_o   = max_q;
        if (drain_s) begin
            out_mant_o = aligned_s;
            out_last_o = (idx_q == IDX_LAST);
        end else begin
            out_mant_o = '0;
            out_last_o = 1'b0;
        end
    end

`ifdef EXP_ALIGN_STICKY_EN
    assign out_sticky_o = drain_s & sticky_s;
`endif

endmodule

// File: tb/tb_exp_align_buffer.sv
// Directed and randomized bench for exp_align_buffer (N=4, EXP_W=8, MANT_W=14, GUARD_W=4).
module tb_exp_align_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  in_exp;
    logic [13:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_mant;
    logic        out_last;
    logic [8:0]  max_exp;
`ifdef EXP_ALIGN_STICKY_EN
    logic        out_sticky;
`endif

    int          n_pass = 0;
    int          n_chk  = 0;
    int          n_fail = 0;
    int          g_exp  [4];
    logic [13:0] g_mant [4];
    int          stall_pct    = 0;
    int          gap_pct      = 0;
    int          forced_stall = 0;

    always #5 clk = ~clk;

    exp_align_buffer dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_exp_i    (in_exp),
        .in_mant_i   (in_mant),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_mant_o  (out_mant),
        .out_last_o  (out_last),
        .max_exp_o   (max_exp)
`ifdef EXP_ALIGN_STICKY_EN
        ,
        .out_sticky_o (out_sticky)
`endif
    );

    task automatic check(input string tag, input longint obs, input longint expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int grp_max();
        int m = g_exp[0];
        for (int i = 1; i < 4; i++) if (g_exp[i] > m) m = g_exp[i];
        return m;
    endfunction

    function automatic longint ref_mant(input int i, input int mx);
        int sh = mx - g_exp[i];
        if (sh >= 18) return 0;
        return (longint'(g_mant[i]) << 4) >> sh;
    endfunction

    function automatic longint ref_sticky(input int i, input int mx);
        int     sh = mx - g_exp[i];
        longint v  = longint'(g_mant[i]) << 4;
        if (sh >= 18) return (v != 0) ? 1 : 0;
        return ((v & ((longint'(1) << sh) - 1)) != 0) ? 1 : 0;
    endfunction

    task automatic set_group(input int e0, input int e1, input int e2, input int e3,
                             input logic [13:0] m);
        g_exp[0] = e0; g_exp[1] = e1; g_exp[2] = e2; g_exp[3] = e3;
        for (int i = 0; i < 4; i++) g_mant[i] = m;
    endtask

    task automatic push_group(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            @(negedge clk);
            for (int g = 0; g < 4 && gap_pct > 0 && $urandom_range(0, 99) < gap_pct; g++) begin
                in_valid = 1'b0;
                check("fill_out_valid", longint'(out_valid), 0);
                @(negedge clk);
            end
            check("fill_in_ready", longint'(in_ready), 1);
            in_valid = 1'b1;
            in_exp   = 9'(g_exp[i]);
            in_mant  = g_mant[i];
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain_group(input int upto);
        int mx = grp_max();
        for (int i = 0; i < upto; i++) begin
            int waited = 0;
            bit done = 1'b0;
            while (!done) begin
                @(negedge clk);
                check("drain_out_valid", longint'(out_valid), 1);
                check("drain_in_ready", longint'(in_ready), 0);
                check($sformatf("out_mant[%0d]", i), longint'(out_mant), ref_mant(i, mx));
                check($sformatf("out_last[%0d]", i), longint'(out_last), (i == 3) ? 1 : 0);
                check("max_exp", longint'($signed(max_exp)), longint'(mx));
`ifdef EXP_ALIGN_STICKY_EN
                check($sformatf("sticky[%0d]", i), longint'(out_sticky), ref_sticky(i, mx));
`endif
                if (forced_stall > 0) begin
                    out_ready = 1'b0;
                    forced_stall--;
                end else begin
                    out_ready = ($urandom_range(0, 99) >= stall_pct);
                end
                waited++;
                if (waited > 40) out_ready = 1'b1;
                if (out_ready) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'b0;
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        check({tag, "_out_valid"}, longint'(out_valid), 0);
        check({tag, "_in_ready"}, longint'(in_ready), 1);
        check({tag, "_out_mant"}, longint'(out_mant), 0);
        check({tag, "_out_last"}, longint'(out_last), 0);
`ifdef EXP_ALIGN_STICKY_EN
        check({tag, "_sticky"}, longint'(out_sticky), 0);
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_exp = 9'd0; in_mant = 14'd0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_idle("reset");
        check("reset_max", longint'(max_exp), 0);

        // Mixed signs
        set_group(3, -2, 5, 5, 14'h2000);
        push_group(4); drain_group(4); check_idle("mixed_end");

        // All negative
        set_group(-10, -3, -7, -3, 14'h3FFF);
        push_group(4); drain_group(4); check_idle("neg_end");

        // Saturation
        set_group(200, -200, 0, 0, 14'h2001);
        push_group(4); drain_group(4); check_idle("sat_end");

        // Backpressure: hold first output for 3 cycles, then stall the third too
        set_group(7, 2, -4, 7, 14'h1235);
        push_group(4);
        forced_stall = 3;
        drain_group(2);
        forced_stall = 3;
        drain_group_rest();
        check_idle("bp_end");

        // Reset mid-DRAIN after 2 outputs
        set_group(100, 90, 80, 70, 14'h0F0F);
        push_group(4); drain_group(2);
        @(negedge clk);
        rst = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; out_ready = 1'b0;
        check_idle("rst_drain");
        check("rst_drain_max", longint'(max_exp), 0);

        // Reset mid-FILL with a larger partial group, then a clean group of 1s
        set_group(120, 120, 120, 120, 14'h1111);
        push_group(2);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        set_group(1, 1, 1, 1, 14'h2AAA);
        push_group(4); drain_group(4); check_idle("ones_end");

        // Minimum exponent, all equal
        set_group(-256, -256, -256, -256, 14'h3A5C);
        push_group(4); drain_group(4); check_idle("min_end");

        // Randomized groups with input gaps and output stalls
        gap_pct = 30; stall_pct = 40;
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 4; i++) begin
                g_exp[i]  = int'($urandom_range(0, 511)) - 256;
                if (r % 3 == 0) g_exp[i] = int'($urandom_range(0, 20)) - 10;
                g_mant[i] = 14'($urandom);
            end
            push_group(4); drain_group(4); check_idle("rand_end");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Drains entries 2 and 3 of the current group, keeping the reference index aligned.
    task automatic drain_group_rest();
        int mx = grp_max();
        for (int i = 2; i < 4; i++) begin
            int waited = 0;
            bit done = 1'b0;
            while (!done) begin
                @(negedge clk);
                check("rest_out_valid", longint'(out_valid), 1);
                check("rest_in_ready", longint'(in_ready), 0);
                check($sformatf("rest_mant[%0d]", i), longint'(out_mant), ref_mant(i, mx));
                check($sformatf("rest_last[%0d]", i), longint'(out_last), (i == 3) ? 1 : 0);
                check("rest_max", longint'($signed(max_exp)), longint'(mx));
                if (forced_stall > 0) begin
                    out_ready = 1'b0;
                    forced_stall--;
                end else begin
                    out_ready = 1'b1;
                end
                waited++;
                if (waited > 40) out_ready = 1'b1;
                if (out_ready) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'b0;
                    done = 1'b1;
                end
            end
        end
    endtask

endmodule
